// File: rtl/conv_stream_if.sv
// Stream channel between the host and a convolution engine: x samples out, y results back.
interface conv_stream_if #(
  parameter int T = 16
);
  logic [T-1:0] x_data;
  logic         x_valid;
  logic         x_ready;
  logic [T-1:0] y_data;
  logic         y_valid;
  logic         y_ready;

  modport master (
    output x_data, x_valid, y_ready,
    input  x_ready, y_data, y_valid
  );

  modport slave (
    input  x_data, x_valid, y_ready,
    output x_ready, y_data, y_valid
  );
endinterface

// File: rtl/conv_stream_host.sv
// Host endpoint: streams a preloaded input vector to a conv engine and captures its results.
// Optional random back-pressure/stall generation under `CONV_HOST_STALL_EN.
module conv_stream_host #(
  parameter int          T         = 16,
  parameter int          SIZE_X    = 96,
  parameter int          SIZE_F    = 65,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   start_i,
  input  logic                                   load_en_i,
  input  logic [$clog2(SIZE_X)-1:0]              load_addr_i,
  input  logic [T-1:0]                           load_data_i,
  conv_stream_if.master                          bus,
  input  logic [$clog2(SIZE_X-SIZE_F+1)-1:0]     rd_addr_i,
  output logic [T-1:0]                           rd_data_o,
  output logic                                   busy_o,
  output logic                                   done_o,
  output logic [$clog2(SIZE_X-SIZE_F+1):0]       y_count_o
);
  localparam int NY = SIZE_X - SIZE_F + 1;
  localparam int AW = $clog2(SIZE_X);
  localparam int SW = $clog2(SIZE_X + 1);
  localparam int RW = $clog2(NY);
  localparam int CW = $clog2(NY) + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] send_q, send_d;
  logic [CW-1:0] ycnt_q, ycnt_d;
  logic          xvld_q, xvld_d;
  logic          yrdy_q, yrdy_d;
  logic [T-1:0]  rd_q;
  logic [T-1:0]  xbuf [SIZE_X];
  logic [T-1:0]  ybuf [NY];
  logic [AW-1:0] xsel;
  logic          x_fire, y_fire;
  logic          x_gate, y_gate;

`ifdef CONV_HOST_STALL_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; only advances while a run is active
  always_ff @(posedge clk) begin
    if (reset)
      lfsr_q <= LFSR_SEED;
    else if (state_q == S_RUN)
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign x_gate = ~lfsr_q[0];
  assign y_gate = ~lfsr_q[1];
`else
  assign x_gate = 1'b1;
  assign y_gate = 1'b1;
`endif

  assign x_fire = xvld_q & bus.x_ready;
  assign y_fire = yrdy_q & bus.y_valid;

  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    ycnt_d  = ycnt_q;
    xvld_d  = xvld_q;
    yrdy_d  = yrdy_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        xvld_d = 1'b0;
        yrdy_d = 1'b0;
        if (start_i) begin
          state_d = S_RUN;
          send_d  = '0;
          ycnt_d  = '0;
          xvld_d  = x_gate;
          yrdy_d  = y_gate;
        end
      end
      S_RUN: begin
        send_d = send_q + SW'(x_fire);
        ycnt_d = ycnt_q + CW'(y_fire);
        if (ycnt_d == CW'(NY)) begin
          state_d = S_DONE;
          xvld_d  = 1'b0;
          yrdy_d  = 1'b0;
        end else begin
          // a pending offer is never withdrawn; a new one may only start when the gate allows
          xvld_d = (send_d < SW'(SIZE_X)) && ((xvld_q && !x_fire) || x_gate);
          yrdy_d = y_gate;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      send_q  <= '0;
      ycnt_q  <= '0;
      xvld_q  <= 1'b0;
      yrdy_q  <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
      ycnt_q  <= ycnt_d;
      xvld_q  <= xvld_d;
      yrdy_q  <= yrdy_d;
      rd_q    <= (int'(rd_addr_i) < NY) ? ybuf[rd_addr_i] : '0;
    end
  end

  // Buffers carry no reset so their contents survive a mid-run reset
  always_ff @(posedge clk) begin
    if (load_en_i && state_q != S_RUN && int'(load_addr_i) < SIZE_X)
      xbuf[load_addr_i] <= load_data_i;
    if (y_fire && !reset)
      ybuf[ycnt_q[RW-1:0]] <= bus.y_data;
  end

  assign xsel        = (send_q < SW'(SIZE_X)) ? send_q[AW-1:0] : '0;
  assign bus.x_data  = xbuf[xsel];
  assign bus.x_valid = xvld_q;
  assign bus.y_ready = yrdy_q;
  assign rd_data_o   = rd_q;
  assign busy_o      = (state_q == S_RUN);
  assign done_o      = (state_q == S_DONE);
  assign y_count_o   = ycnt_q;
endmodule

// File: tb/tb_conv_stream_host.sv
// Self-checking bench for conv_stream_host (default build): vector table, directed corners, random runs.
module tb_conv_stream_host;
  localparam int T      = 16;
  localparam int SIZE_X = 96;
  localparam int SIZE_F = 65;
  localparam int NY     = SIZE_X - SIZE_F + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic         load_en_i = 1'b0;
  logic [6:0]   load_addr_i = '0;
  logic [T-1:0] load_data_i = '0;
  logic [4:0]   rd_addr_i = '0;
  logic [T-1:0] rd_data_o;
  logic         busy_o, done_o;
  logic [5:0]   y_count_o;

  conv_stream_if #(.T(T)) bus ();

  conv_stream_host #(.T(T), .SIZE_X(SIZE_X), .SIZE_F(SIZE_F), .LFSR_SEED(16'hACE1)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .load_en_i(load_en_i),
    .load_addr_i(load_addr_i), .load_data_i(load_data_i), .bus(bus),
    .rd_addr_i(rd_addr_i), .rd_data_o(rd_data_o), .busy_o(busy_o),
    .done_o(done_o), .y_count_o(y_count_o)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;
  logic [T-1:0] xm [SIZE_X];   // what the input buffer should hold
  logic [T-1:0] ym [NY];       // results the host accepted, in order

  typedef struct {
    logic st, xr, yv; logic [T-1:0] yd;
    logic exv; logic [T-1:0] exd; logic eyr, ebusy, edone; logic [5:0] eyc;
  } vec_t;
  vec_t tbl [6];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic load_all(input bit seq);
    for (int i = 0; i < SIZE_X; i++) begin
      @(negedge clk);
      xm[i] = seq ? T'(i) : T'($urandom);
      load_en_i = 1'b1; load_addr_i = 7'(i); load_data_i = xm[i];
    end
    @(negedge clk);
    load_en_i = 1'b0;
  endtask

  // One full run; the bench plays the engine and only offers result k after SIZE_F+k samples
  task automatic do_run(input int xr_pct, input int yv_pct, input bit seq_y,
                        input bit stall_win, input logic [T-1:0] new0);
    int xn = 0, yn = 0, cyc = 0, lo = 0;
    bit hold = 0, fin = 0;
    logic [T-1:0] hd = '0, yd;
    @(negedge clk);
    bus.x_ready = 1'b0; bus.y_valid = 1'b0;
    start_i = 1'b1; load_en_i = 1'b1; load_addr_i = '0; load_data_i = new0;
    xm[0] = new0;
    @(negedge clk);
    start_i = 1'b0; load_en_i = 1'b0;
    chk("start_busy", busy_o, 1);
    chk("start_xdata", bus.x_data, xm[0]);
    forever begin
      if (fin) begin
        chk("done_hi", done_o, 1);
        chk("done_busy_lo", busy_o, 0);
        chk("done_yready_lo", bus.y_ready, 0);
        chk("done_xvalid_lo", bus.x_valid, 0);
        chk("done_ycount", y_count_o, NY);
        chk("done_xsent", xn, SIZE_X);
        break;
      end
      if (hold) begin
        chk("xvalid_hold", bus.x_valid, 1);
        chk("xdata_hold", bus.x_data, hd);
      end
      chk("xvalid_lvl", bus.x_valid, xn < SIZE_X);
      chk("yready_lvl", bus.y_ready, 1);
      chk("ycount_run", y_count_o, yn);
      chk("done_lo_run", done_o, 0);
      if (cyc++ > 4000) begin chk("run_timeout", 0, 1); break; end
      bus.x_ready = ($urandom_range(99) < xr_pct);
      if (stall_win && xn == 9 && lo < 5) begin
        bus.x_ready = 1'b0; lo++;
        chk("stall_xdata", bus.x_data, xm[9]);
      end
      yd = seq_y ? T'(100 + yn) : T'($urandom);
      bus.y_valid = (xn >= SIZE_F + yn) && ($urandom_range(99) < yv_pct);
      bus.y_data  = yd;
      load_en_i = (cyc == 3);
      load_addr_i = 7'd5; load_data_i = ~xm[5];
      #1;
      hold = bus.x_valid && !bus.x_ready;
      hd = bus.x_data;
      if (bus.x_valid && bus.x_ready) begin chk("xbeat", bus.x_data, xm[xn]); xn++; end
      if (bus.y_valid && bus.y_ready) begin ym[yn] = yd; yn++; fin = (yn == NY); end
      @(negedge clk);
    end
    load_en_i = 1'b0;
    // extra beat after completion must be refused
    bus.x_ready = 1'b1; bus.y_valid = 1'b1; bus.y_data = 16'd999;
    #1 chk("extra_yready", bus.y_ready, 0);
    @(negedge clk);
    chk("extra_ycount", y_count_o, NY);
    chk("extra_done", done_o, 1);
    bus.y_valid = 1'b0;
    for (int k = 0; k < NY; k++) begin
      @(negedge clk); rd_addr_i = 5'(k);
      @(posedge clk); #1;
      chk("readback", rd_data_o, ym[k]);
    end
  endtask

  initial begin
    bus.x_ready = 1'b0; bus.y_valid = 1'b0; bus.y_data = '0;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 16'd0,   1'b0, 16'd0, 1'b0, 1'b0, 1'b0, 6'd0};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 16'd0, 1'b1, 1'b1, 1'b0, 6'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'd0,   1'b1, 16'd1, 1'b1, 1'b1, 1'b0, 6'd0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 16'd500, 1'b1, 16'd2, 1'b1, 1'b1, 1'b0, 6'd1};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 16'd0,   1'b1, 16'd2, 1'b1, 1'b1, 1'b0, 6'd1};
    tbl[5] = '{1'b0, 1'b1, 1'b0, 16'd0,   1'b1, 16'd3, 1'b1, 1'b1, 1'b0, 6'd1};

    repeat (2) @(negedge clk);
    chk("rst_xvalid", bus.x_valid, 0);
    chk("rst_yready", bus.y_ready, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ycount", y_count_o, 0);
    chk("rst_rddata", rd_data_o, 0);
    reset = 1'b0;
    load_all(1'b1);
    chk("idle_xdata", bus.x_data, xm[0]);

    for (int r = 0; r < 6; r++) begin
      @(negedge clk);
      start_i = tbl[r].st; bus.x_ready = tbl[r].xr;
      bus.y_valid = tbl[r].yv; bus.y_data = tbl[r].yd;
      @(posedge clk); #1;
      chk($sformatf("vec%0d_xvalid", r), bus.x_valid, tbl[r].exv);
      chk($sformatf("vec%0d_xdata", r), bus.x_data, tbl[r].exd);
      chk($sformatf("vec%0d_yready", r), bus.y_ready, tbl[r].eyr);
      chk($sformatf("vec%0d_busy", r), busy_o, tbl[r].ebusy);
      chk($sformatf("vec%0d_done", r), done_o, tbl[r].edone);
      chk($sformatf("vec%0d_ycount", r), y_count_o, tbl[r].eyc);
    end
    @(negedge clk);
    start_i = 1'b0; bus.x_ready = 1'b0; bus.y_valid = 1'b0; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("vec_rst_busy", busy_o, 0);

    do_run(100, 100, 1'b1, 1'b0, 16'd0);    // back-to-back, y = 100+k
    do_run(100, 100, 1'b1, 1'b1, 16'd0);    // x_ready stall window on sample 9

    // reset at send_idx = 40, then restart from xbuf[0]
    begin
      int xn = 0, cyc = 0;
      @(negedge clk); start_i = 1'b1;
      @(negedge clk); start_i = 1'b0; bus.x_ready = 1'b1;
      while (xn < 40 && cyc < 200) begin
        #1; if (bus.x_valid && bus.x_ready) xn++;
        cyc++;
        @(negedge clk);
      end
      chk("mid_sent40", xn, 40);
      reset = 1'b1; bus.x_ready = 1'b0;
      @(posedge clk); #1;
      chk("mid_busy", busy_o, 0);
      chk("mid_xvalid", bus.x_valid, 0);
      chk("mid_ycount", y_count_o, 0);
      chk("mid_xdata", bus.x_data, xm[0]);
      @(negedge clk); reset = 1'b0;
    end
    do_run(100, 100, 1'b1, 1'b0, 16'd0);

    load_all(1'b0);
    do_run(60, 50, 1'b0, 1'b0, T'($urandom));
    do_run(35, 80, 1'b0, 1'b0, T'($urandom));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
